// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer: shift-add multiply, restoring divide, one bit per cycle.
// Optional feature: define MDU_EARLY_OUT_EN to let MUL/MULHU finish once the multiplier is exhausted.
module mdu_seq_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} stateT;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN);
  localparam logic [2:0] OpMul   = 3'd0;
  localparam logic [2:0] OpMulhu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpRem   = 3'd4;
  localparam logic [2:0] OpRemu  = 3'd5;

  stateT              stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [2:0]         opQ, opD;
  logic [2*XLEN-1:0]  prodQ, prodD;
  logic [2*XLEN-1:0]  mcandQ, mcandD;
  logic [XLEN-1:0]    mplrQ, mplrD;
  logic [XLEN-1:0]    remQ, remD;
  logic [XLEN-1:0]    quoQ, quoD;
  logic [XLEN-1:0]    dvsrQ, dvsrD;
  logic               quoNegQ, quoNegD;
  logic               remNegQ, remNegD;
  logic [XLEN-1:0]    resultQ, resultD;

  logic               src1Neg, src2Neg, signedOp, divByZero, overflow;
  logic [XLEN-1:0]    mag1, mag2, minVal;
  logic [2*XLEN-1:0]  mulAdd;
  logic [XLEN-1:0]    mulMplr;
  logic [XLEN:0]      divShift, divDiff;
  logic               divGe;
  logic [XLEN-1:0]    divRem, divQuo;
  logic [CNT_W-1:0]   cntInc;
  logic               lastIter;

  assign in_ready   = (stateQ == StIdle);
  assign out_valid  = (stateQ == StDone);
  assign busy       = (stateQ != StIdle);
  assign out_result = resultQ;

  // Operand conditioning at accept: magnitudes for signed divide, fast-path detection.
  always_comb begin
    minVal    = '0;
    minVal[XLEN-1] = 1'b1;
    src1Neg   = in_src1[XLEN-1];
    src2Neg   = in_src2[XLEN-1];
    signedOp  = (in_op == OpDiv) || (in_op == OpRem);
    divByZero = (in_src2 == '0);
    overflow  = signedOp && (in_src1 == minVal) && (in_src2 == '1);
    mag1      = (signedOp && src1Neg) ? -in_src1 : in_src1;
    mag2      = (signedOp && src2Neg) ? -in_src2 : in_src2;
  end

  // One iteration of each datapath, evaluated from current state.
  always_comb begin
    mulAdd   = mplrQ[0] ? (prodQ + mcandQ) : prodQ;
    mulMplr  = mplrQ >> 1;
    divShift = {remQ, quoQ[XLEN-1]};
    divDiff  = divShift - {1'b0, dvsrQ};
    divGe    = ~divDiff[XLEN];
    divRem   = divGe ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
    divQuo   = {quoQ[XLEN-2:0], divGe};
    cntInc   = (cntQ == CntLast) ? cntQ : cntQ + CNT_W'(1);
`ifdef MDU_EARLY_OUT_EN
    lastIter = (cntInc == CntLast) || ((opQ <= OpMulhu) && (mulMplr == '0));
`else
    lastIter = (cntInc == CntLast);
`endif
  end

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    opD     = opQ;
    prodD   = prodQ;
    mcandD  = mcandQ;
    mplrD   = mplrQ;
    remD    = remQ;
    quoD    = quoQ;
    dvsrD   = dvsrQ;
    quoNegD = quoNegQ;
    remNegD = remNegQ;
    resultD = resultQ;

    unique case (stateQ)
      StIdle: begin
        if (in_valid && !flush) begin
          opD     = in_op;
          cntD    = '0;
          prodD   = '0;
          mcandD  = {{XLEN{1'b0}}, in_src1};
          mplrD   = in_src2;
          remD    = '0;
          quoD    = mag1;
          dvsrD   = mag2;
          quoNegD = signedOp && (src1Neg ^ src2Neg);
          remNegD = signedOp && src1Neg;
          if (in_op > OpRemu) begin
            resultD = '0;
            stateD  = StDone;
          end else if ((in_op >= OpDiv) && divByZero) begin
            resultD = ((in_op == OpDiv) || (in_op == OpDivu)) ? '1 : in_src1;
            stateD  = StDone;
          end else if (overflow) begin
            resultD = (in_op == OpDiv) ? in_src1 : '0;
            stateD  = StDone;
          end else begin
            stateD  = StCalc;
          end
        end
      end
      StCalc: begin
        cntD = cntInc;
        if (opQ <= OpMulhu) begin
          prodD  = mulAdd;
          mcandD = mcandQ << 1;
          mplrD  = mulMplr;
          if (lastIter) begin
            resultD = (opQ == OpMul) ? mulAdd[XLEN-1:0] : mulAdd[2*XLEN-1:XLEN];
            stateD  = StDone;
          end
        end else begin
          remD = divRem;
          quoD = divQuo;
          if (lastIter) begin
            // Signs restored on the way into DONE; unsigned ops have both flags clear.
            if ((opQ == OpDiv) || (opQ == OpDivu)) begin
              resultD = quoNegQ ? -divQuo : divQuo;
            end else begin
              resultD = remNegQ ? -divRem : divRem;
            end
            stateD = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase

    if (flush) begin
      stateD = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      opQ     <= '0;
      prodQ   <= '0;
      mcandQ  <= '0;
      mplrQ   <= '0;
      remQ    <= '0;
      quoQ    <= '0;
      dvsrQ   <= '0;
      quoNegQ <= 1'b0;
      remNegQ <= 1'b0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      opQ     <= opD;
      prodQ   <= prodD;
      mcandQ  <= mcandD;
      mplrQ   <= mplrD;
      remQ    <= remD;
      quoQ    <= quoD;
      dvsrQ   <= dvsrD;
      quoNegQ <= quoNegD;
      remNegQ <= remNegD;
      resultQ <= resultD;
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: arithmetic reference model checked every cycle plus directed literals.
module tb_mdu_seq_ctrl;

  localparam int XLEN = 64;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  localparam logic [63:0] MinVal = 64'h8000_0000_0000_0000;
  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2, out_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mdu_seq_ctrl #(.XLEN(64), .CNT_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] modelRes(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r;
    logic         ovf;
    p   = {64'd0, a} * {64'd0, b};
    ovf = (a == MinVal) && (b == AllOnes);
    r   = '0;
    case (op)
      3'd0: r = p[63:0];
      3'd1: r = p[127:64];
      3'd2: if (b == 0) r = AllOnes; else if (ovf) r = a; else r = $signed(a) / $signed(b);
      3'd3: if (b == 0) r = AllOnes; else r = a / b;
      3'd4: if (b == 0) r = a; else if (ovf) r = '0; else r = $signed(a) % $signed(b);
      3'd5: if (b == 0) r = a; else r = a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycles from accept edge to first out_valid, counting the accept-following cycle as 1.
  function automatic int modelLat(input logic [2:0] op, input logic [63:0] a,
                                  input logic [63:0] b);
    int n;
    if (op > 3'd5) return 1;
    if (op >= 3'd2 && b == 0) return 1;
    if ((op == 3'd2 || op == 3'd4) && a == MinVal && b == AllOnes) return 1;
    if (op <= 3'd1 && EarlyOut) begin
      n = 1;
      for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
      return n + 1;
    end
    return XLEN + 1;
  endfunction

  // Reference process: tracks one outstanding op and checks outputs on every cycle.
  bit          pending = 1'b0;
  int          doneCyc = 0;
  logic [63:0] expRes = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
        chk("rst in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst out_result", out_result, 64'd0);
        chk("rst busy", {63'd0, busy}, 64'd0);
      end else begin
        chk("model in_ready", {63'd0, in_ready}, {63'd0, !pending});
        chk("model busy", {63'd0, busy}, {63'd0, pending});
        if (pending && cyc >= doneCyc) begin
          chk("model out_valid", {63'd0, out_valid}, 64'd1);
          chk("model out_result", out_result, expRes);
        end else begin
          chk("model out_valid", {63'd0, out_valid}, 64'd0);
        end
        if (!pending && in_valid && !flush) begin
          pending = 1'b1;
          expRes  = modelRes(in_op, in_src1, in_src2);
          doneCyc = cyc + modelLat(in_op, in_src1, in_src2);
        end else if (pending && flush) begin
          pending = 1'b0;
        end else if (pending && cyc >= doneCyc && out_ready) begin
          pending = 1'b0;
        end
      end
    end
  end

  task automatic issueOp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    @(posedge clk); #1;
    // Scramble inputs after accept; the DUT must have latched them.
    in_valid = 1'b0; in_op = ~op; in_src1 = ~a; in_src2 = b ^ 64'h5A5A_5A5A_0F0F_F0F0;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lit, input int latLit,
                       input int hold);
    int n;
    bit seen;
    issueOp(op, a, b);
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else n++;
    end
    chk({name, " latency"}, 64'(n), 64'(latLit));
    chk({name, " result"}, out_result, lit);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({name, " held result"}, out_result, lit);
      chk({name, " held in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " idle after handshake"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    runOp("mul 7*6", 3'd0, 64'd7, 64'd6, 64'd42, EarlyOut ? 4 : 65, 0);
    runOp("mulhu max*2", 3'd1, AllOnes, 64'd2, 64'd1, EarlyOut ? 3 : 65, 0);
    runOp("mul max*2", 3'd0, AllOnes, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, EarlyOut ? 3 : 65, 0);
    runOp("mul 5*0", 3'd0, 64'd5, 64'd0, 64'd0, EarlyOut ? 2 : 65, 0);
    runOp("mul 5*1", 3'd0, 64'd5, 64'd1, 64'd5, EarlyOut ? 2 : 65, 0);
    runOp("div -7/2", 3'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    runOp("rem -7/2", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, AllOnes, 65, 0);
    runOp("div 7/-2", 3'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    runOp("rem 7/-2", 3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 0);
    runOp("divu 100/7", 3'd3, 64'd100, 64'd7, 64'd14, 65, 0);
    runOp("remu 100/7", 3'd5, 64'd100, 64'd7, 64'd2, 65, 0);
    runOp("divu max/3", 3'd3, AllOnes, 64'd3, 64'h5555_5555_5555_5555, 65, 0);
    runOp("div 9/0", 3'd2, 64'd9, 64'd0, AllOnes, 1, 0);
    runOp("divu 9/0", 3'd3, 64'd9, 64'd0, AllOnes, 1, 0);
    runOp("rem 5/0", 3'd4, 64'd5, 64'd0, 64'd5, 1, 0);
    runOp("div min/-1", 3'd2, MinVal, AllOnes, MinVal, 1, 0);
    runOp("rem min/-1", 3'd4, MinVal, AllOnes, 64'd0, 1, 0);
    runOp("reserved op", 3'd6, 64'd3, 64'd4, 64'd0, 1, 0);
    runOp("mul hold", 3'd0, 64'd7, 64'd6, 64'd42, EarlyOut ? 4 : 65, 10);

    // Flush mid-divide: op is dropped, out_valid never rises.
    issueOp(3'd3, 64'd100, 64'd7);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    repeat (70) @(posedge clk);
    runOp("mul 3*3 after flush", 3'd0, 64'd3, 64'd3, 64'd9, EarlyOut ? 3 : 65, 0);

    // Flush together with a request in IDLE: not accepted.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 64'd2; in_src2 = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush idle busy", {63'd0, busy}, 64'd0);
    chk("flush idle in_ready", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of a divide.
    issueOp(3'd2, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("mid rst busy", {63'd0, busy}, 64'd0);
    chk("mid rst out_result", out_result, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    runOp("divu after rst", 3'd3, 64'd1000, 64'd3, 64'd333, 65, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
